// File: rtl/pkt_sender_pkg.sv
// Shared constants and types for pkt_sender. Optional build macro: PKT_SENDER_STATS_EN.
// Packet geometry comes from `MAX_PACKET_LENGHT and `FLIT_WIDTH (defaults 4 and 32).
`ifndef MAX_PACKET_LENGHT
`define MAX_PACKET_LENGHT 4
`endif
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif

package pkt_sender_pkg;

  localparam int FLIT_W        = `FLIT_WIDTH;
  localparam int MAX_PKT_LEN   = `MAX_PACKET_LENGHT;
  localparam int PKT_W         = FLIT_W * MAX_PKT_LEN;
  localparam int FLIT_TYPE_LSB = FLIT_W - 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // The tail bit ends a packet; a full-length packet is cut at its last slot regardless.
  function automatic logic flit_is_last(input logic [FLIT_W-1:0] flit, input logic idx_at_end);
    return flit[FLIT_TYPE_LSB] | idx_at_end;
  endfunction

endpackage

// File: rtl/pkt_sender_credit.sv
// Per-vnet credit counter: starts full, counts down on send, up on return,
// saturates at full and raises a sticky error when a return would overflow.
module pkt_sender_credit #(
  parameter int CREDITS = 4,
  parameter int CW      = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_inc,
  input  logic          i_dec,
  output logic [CW-1:0] o_cnt,
  output logic          o_err
);

  localparam logic [CW-1:0] FULL = CW'(CREDITS);

  logic [CW-1:0] r_cnt;
  logic          r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= FULL;
      r_err <= 1'b0;
    end else if (i_inc && !i_dec) begin
      if (r_cnt == FULL) r_err <= 1'b1;
      else               r_cnt <= r_cnt + 1'b1;
    end else if (i_dec && !i_inc) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_err = r_err;

endmodule

// File: rtl/pkt_sender.sv
// Packet-to-flit serializer with per-vnet credit flow control toward the router local port.
// Optional build macro: PKT_SENDER_STATS_EN adds pkt_cnt_o / stall_cnt_o.
module pkt_sender
  import pkt_sender_pkg::*;
#(
  parameter int N_BITS_VNET_ID   = 2,
  parameter int N_BITS_FLIT_IDX  = 3,
  parameter int CREDITS_PER_VNET = 4,
  parameter int N_BITS_CREDIT    = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PKT_W-1:0]              pkt_i,
  input  logic [N_BITS_VNET_ID-1:0]     vnet_id_i,
  input  logic                          is_valid_i,
  output logic                          ready_o,
  output logic [FLIT_W-1:0]             flit_o,
  output logic                          flit_valid_o,
  output logic [N_BITS_VNET_ID-1:0]     flit_vnet_o,
  input  logic [(2**N_BITS_VNET_ID)-1:0] credit_i,
  output logic                          credit_err_o
`ifdef PKT_SENDER_STATS_EN
  ,
  output logic [15:0]                   pkt_cnt_o,
  output logic [15:0]                   stall_cnt_o
`endif
);

  localparam int N_VNETS = 2**N_BITS_VNET_ID;

  state_e                      r_state;
  state_e                      w_state_nxt;
  logic [PKT_W-1:0]            r_pkt;
  logic [N_BITS_VNET_ID-1:0]   r_vnet;
  logic [N_BITS_FLIT_IDX-1:0]  r_idx;
  logic [FLIT_W-1:0]           w_flit;
  logic                        w_last;
  logic                        w_send;
  logic                        w_stall;
  logic [N_BITS_CREDIT-1:0]    w_cnt [N_VNETS];
  logic [N_VNETS-1:0]          w_dec;
  logic [N_VNETS-1:0]          w_err;

  always_comb begin
    w_flit = '0;
    for (int k = 0; k < MAX_PKT_LEN; k++) begin
      if (r_idx == N_BITS_FLIT_IDX'(k)) w_flit = r_pkt[k*FLIT_W +: FLIT_W];
    end
  end

  assign w_last = flit_is_last(w_flit, r_idx == N_BITS_FLIT_IDX'(MAX_PKT_LEN-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (is_valid_i)       w_state_nxt = ST_SEND;
      ST_SEND: if (w_send && w_last) w_state_nxt = ST_IDLE;
      default:                       w_state_nxt = ST_IDLE;
    endcase
  end

  // Send decision uses the registered credit count only; a same-cycle return is not bypassed.
  always_comb begin
    ready_o = (r_state == ST_IDLE);
    w_send  = (r_state == ST_SEND) && (w_cnt[r_vnet] != '0);
    w_stall = (r_state == ST_SEND) && (w_cnt[r_vnet] == '0);
  end

  always_ff @(posedge clk) begin
    if (ready_o && is_valid_i) begin
      r_pkt  <= pkt_i;
      r_vnet <= vnet_id_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  r_idx <= '0;
    else if (ready_o)          r_idx <= '0;
    else if (w_send && !w_last) r_idx <= r_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flit_o       <= '0;
      flit_valid_o <= 1'b0;
      flit_vnet_o  <= '0;
    end else begin
      flit_valid_o <= w_send;
      if (w_send) begin
        flit_o      <= w_flit;
        flit_vnet_o <= r_vnet;
      end
    end
  end

  for (genvar v = 0; v < N_VNETS; v++) begin : g_credit
    assign w_dec[v] = w_send && (r_vnet == N_BITS_VNET_ID'(v));

    pkt_sender_credit #(
      .CREDITS (CREDITS_PER_VNET),
      .CW      (N_BITS_CREDIT)
    ) u_credit (
      .clk   (clk),
      .rst   (rst),
      .i_inc (credit_i[v]),
      .i_dec (w_dec[v]),
      .o_cnt (w_cnt[v]),
      .o_err (w_err[v])
    );
  end

  assign credit_err_o = |w_err;

`ifdef PKT_SENDER_STATS_EN
  logic [15:0] r_pkt_cnt;
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pkt_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_send && w_last) r_pkt_cnt   <= r_pkt_cnt + 1'b1;
      if (w_stall)          r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign pkt_cnt_o   = r_pkt_cnt;
  assign stall_cnt_o = r_stall_cnt;
`else
  logic w_unused_stall;
  assign w_unused_stall = w_stall;
`endif

endmodule
